// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types for the round-robin mux arbiter
//
// Purpose : state encoding of the output register (empty / holding data).
// Ports   : none (package).
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/output handshake bundle of the arbiter
//
// Purpose : groups the per-requester valid/ready/data lines and the registered
//           output channel.
// Ports   : master - requester/consumer side (drives req_vld, req_data, out_rdy)
//           slave  - arbiter side (drives req_rdy, out_vld, out_data, out_src)
interface mux_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_rdy;
  logic                   out_vld;
  logic [WIDTH-1:0]       out_data;
  logic [IDX_W-1:0]       out_src;
  logic                   out_rdy;

  modport master (
    output req_vld, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, out_src
  );

  modport slave (
    input  req_vld, req_data, out_rdy,
    output req_rdy, out_vld, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// rtl/mux_rr_arbiter_pick.sv - combinational round-robin priority pick
//
// Purpose : finds the first set request at or after ptr, wrapping around.
// Ports   : req       - request vector
//           ptr       - index with highest priority
//           grant     - one-hot grant (zero when no request)
//           grant_idx - index of the granted request
//           any       - at least one request is set
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  localparam int DW = $clog2(2 * N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;
  logic [DW-1:0]      first_pos;

  // Lower copy is masked below ptr; the unmasked upper copy supplies the
  // wrapped-around candidates, so the lowest set bit is the round-robin winner.
  assign dbl    = {req, req};
  assign masked = dbl & ({(2*N_REQ){1'b1}} << ptr);

  always_comb begin
    first_pos = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (masked[i]) first_pos = DW'(i);
    end
  end

  assign any       = |req;
  assign grant_idx = (first_pos >= DW'(N_REQ)) ? IDX_W'(first_pos - DW'(N_REQ))
                                                : IDX_W'(first_pos);
  assign grant     = any ? (N_REQ'(1) << grant_idx) : '0;
endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin shared N-to-1 mux with registered output
//
// Purpose : arbitrates N_REQ valid/ready requesters onto one registered output
//           channel, tagging each word with its source index.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-high reset
//           bus - mux_rr_arbiter_if.slave (requests in, output channel out)
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux_rr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);

  out_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] src_q;

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  rr_priority_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (bus.req_vld),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Slot is free when empty or when the held word leaves this cycle.
  assign slot_free   = (state == ST_EMPTY) || bus.out_rdy;
  assign accept      = any && slot_free && !rst;
  assign bus.req_rdy = accept ? grant : '0;
  assign sel_data    = bus.req_data[grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      ptr    <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= sel_data;
        src_q  <= grant_idx;
        ptr    <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (!accept && bus.out_rdy) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.out_vld  = (state == ST_FULL);
  assign bus.out_data = data_q;
  assign bus.out_src  = src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  mux_rr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  mux_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit           m_vld;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] vld, input int p);
    for (int k = 0; k < N; k++) begin
      if (vld[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0;
  endtask

  // Called just after a falling edge with inputs already driven; checks the
  // cycle, advances the model across the rising edge, returns at next fall.
  task automatic tick(output bit acc, output int g);
    bit           free;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] d;
    #1;
    free = !m_vld || bus.out_rdy;
    g    = model_pick(bus.req_vld, m_ptr);
    acc  = free && (g >= 0);
    exp_rdy = acc ? (N'(1) << g) : '0;
    d = '0;
    if (g >= 0) d = bus.req_data[g*W +: W];
    check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    check("out_vld", 32'(bus.out_vld), 32'(m_vld));
    if (m_vld) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_src", 32'(bus.out_src), 32'(m_src));
    end
    @(posedge clk);
    if (acc) begin
      m_vld = 1; m_data = d; m_src = g; m_ptr = (g + 1) % N;
    end else if (m_vld && bus.out_rdy) begin
      m_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    bus.req_data = {d3, d2, d1, d0};
  endtask

  bit           acc;
  int           g;
  logic [N-1:0] pending;
  logic [W-1:0] pdata [N];
  int           wait_cnt [N];

  initial begin
    rst = 1'b1;
    bus.req_vld = '0; bus.req_data = '0; bus.out_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_vld", 32'(bus.out_vld), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_src", 32'(bus.out_src), 0);
    check("rst_req_rdy", 32'(bus.req_rdy), 0);
    rst = 1'b0;

    // full contention: 0,1,2,3,0,1
    bus.req_vld = 4'b1111; bus.out_rdy = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 6; k++) begin
      tick(acc, g);
      check("rr_src", 32'(bus.out_src), 32'(k % 4));
      check("rr_data", 32'(bus.out_data), 32'(8'h10 + k % 4));
    end

    // single requester 2 (ptr=2 here, ptr=3 afterwards)
    bus.req_vld = 4'b0100; set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick(acc, g);
      check("single_data", 32'(bus.out_data), 32'h A5);
      check("single_src", 32'(bus.out_src), 2);
    end

    // skip and wrap from ptr=3: grants 0,1,0
    bus.req_vld = 4'b0011; set_data(8'h30, 8'h31, 8'h00, 8'h00);
    tick(acc, g); check("wrap_src0", 32'(bus.out_src), 0);
    tick(acc, g); check("wrap_src1", 32'(bus.out_src), 1);
    tick(acc, g); check("wrap_src2", 32'(bus.out_src), 0);

    // backpressure: 3 stalled cycles, then release accepts requester 1
    bus.req_vld = 4'b1111; bus.out_rdy = 1'b0;
    set_data(8'h40, 8'h41, 8'h42, 8'h43);
    for (int k = 0; k < 3; k++) begin
      tick(acc, g);
      check("bp_data", 32'(bus.out_data), 32'h30);
      check("bp_src", 32'(bus.out_src), 0);
    end
    bus.out_rdy = 1'b1;
    #1 check("bp_release_rdy", 32'(bus.req_rdy), 32'b0010);
    tick(acc, g);
    check("bp_release_src", 32'(bus.out_src), 1);

    // reset while holding valid data
    #2 rst = 1'b1;
    #1;
    check("midrst_out_vld", 32'(bus.out_vld), 0);
    check("midrst_out_src", 32'(bus.out_src), 0);
    check("midrst_req_rdy", 32'(bus.req_rdy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_vld = 4'b1111;
    tick(acc, g);
    check("post_rst_src", 32'(bus.out_src), 0);

    // random soak with stable-until-accept requesters
    pending = '0;
    for (int i = 0; i < N; i++) begin pdata[i] = '0; wait_cnt[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i]  = 1'b1;
          pdata[i]    = W'($urandom);
          wait_cnt[i] = 0;
        end
        bus.req_data[i*W +: W] = pdata[i];
      end
      bus.req_vld = pending;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      tick(acc, g);
      if (acc) begin
        for (int i = 0; i < N; i++) if (pending[i]) wait_cnt[i]++;
        check("fair_wait", 32'(wait_cnt[g] <= N), 1);
        pending[g] = 1'b0;
      end
    end

    // drain
    bus.req_vld = '0; bus.out_rdy = 1'b1;
    repeat (3) tick(acc, g);
    check("drain_out_vld", 32'(bus.out_vld), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
